// File: rtl/hilo_div_pkg.sv
// rtl/hilo_div_pkg.sv - op codes, FSM state type and default width for the HI/LO divide controller
package hilo_div_pkg;

  localparam int W_DEF = 32;

  localparam logic [2:0] OP_DIV  = 3'd0;
  localparam logic [2:0] OP_DIVU = 3'd1;
  localparam logic [2:0] OP_MTHI = 3'd2;
  localparam logic [2:0] OP_MTLO = 3'd3;
  localparam logic [2:0] OP_MFHI = 3'd4;
  localparam logic [2:0] OP_MFLO = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FIX    = 2'd3
  } state_e;

endpackage

// File: rtl/hilo_div_sign_fix.sv
// rtl/hilo_div_sign_fix.sv - conditional two's-complement negate
module sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/hilo_div_ctrl.sv
// rtl/hilo_div_ctrl.sv - DIV/DIVU/MT/MF sequencer owning HI/LO; signed correction under HILO_DIV_SIGNED_EN
module hilo_div_ctrl
  import hilo_div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         op_valid,
  input  logic [2:0]   op_code,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         flush,
  output logic         stall,
  output logic [W-1:0] rd_data,
  output logic         div_start,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic [W-1:0] div_q,
  input  logic [W-1:0] div_r,
  input  logic         div_busy,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  state_e       state_q, state_d;
  logic [W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
  logic [W-1:0] a_mag, b_mag, lo_res, hi_res;
  logic         known_op;

`ifdef HILO_DIV_SIGNED_EN
  logic q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic a_neg, b_neg;

  assign a_neg = (op_code == OP_DIV) & op_a[W-1];
  assign b_neg = (op_code == OP_DIV) & op_b[W-1];

  sign_fix #(.W(W)) u_fix_a  (.neg(a_neg),   .din(op_a),  .dout(a_mag));
  sign_fix #(.W(W)) u_fix_b  (.neg(b_neg),   .din(op_b),  .dout(b_mag));
  sign_fix #(.W(W)) u_fix_lo (.neg(q_neg_q), .din(div_q), .dout(lo_res));
  sign_fix #(.W(W)) u_fix_hi (.neg(r_neg_q), .din(div_r), .dout(hi_res));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  always_comb begin
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    if (state_q == ST_IDLE && op_valid && (op_code == OP_DIV || op_code == OP_DIVU)) begin
      q_neg_d = a_neg ^ b_neg;
      r_neg_d = a_neg;
    end
  end
`else
  // Unsigned build: DIV is plain DIVU, no negation hardware at all.
  assign a_mag  = op_a;
  assign b_mag  = op_b;
  assign lo_res = div_q;
  assign hi_res = div_r;
`endif

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_DIV, OP_DIVU: begin
              if (op_b == '0) begin
                hi_d = op_a;
                lo_d = '1;
              end else begin
                div_a_d = a_mag;
                div_b_d = b_mag;
                state_d = ST_LAUNCH;
              end
            end
            OP_MTHI: hi_d = op_a;
            OP_MTLO: lo_d = op_a;
            default: ;
          endcase
        end
      end
      ST_LAUNCH: state_d = flush ? ST_IDLE : ST_WAIT;
      // div_busy is already high on the first WAIT edge, so it alone marks completion.
      ST_WAIT: begin
        if (flush)          state_d = ST_IDLE;
        else if (!div_busy) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (!flush) begin
          lo_d = lo_res;
          hi_d = hi_res;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign known_op = (op_code <= OP_MFLO);

  always_comb begin
    stall     = op_valid && known_op && (state_q != ST_IDLE);
    div_start = (state_q == ST_LAUNCH);
    rd_data   = '0;
    if (op_valid && op_code == OP_MFHI) rd_data = hi_q;
    if (op_valid && op_code == OP_MFLO) rd_data = lo_q;
  end

  assign div_a = div_a_q;
  assign div_b = div_b_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// tb/tb_hilo_div_ctrl.sv - directed self-checking bench for hilo_div_ctrl with a 32-iteration divider model
module tb_hilo_div_ctrl;
  import hilo_div_pkg::*;

  logic        clock = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        stall;
  logic [31:0] rd_data;
  logic        div_start;
  logic [31:0] div_a, div_b, div_q, div_r;
  logic        div_busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;

  hilo_div_ctrl #(.W(32)) dut (
    .clock(clock), .resetn(resetn), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .flush(flush), .stall(stall), .rd_data(rd_data),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_q(div_q),
    .div_r(div_r), .div_busy(div_busy), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  // Divider model: loads on the falling edge when started, busy for 33 falling edges after the load.
  logic [31:0] dv_a, dv_b;
  int          dv_cnt = 0;
  initial begin
    div_busy = 1'b0;
    div_q    = '0;
    div_r    = '0;
    dv_a     = '0;
    dv_b     = 32'd1;
  end
  always @(negedge clock) begin
    if (div_start) begin
      n_start  <= n_start + 1;
      dv_a     <= div_a;
      dv_b     <= div_b;
      div_busy <= 1'b1;
      dv_cnt   <= 33;
    end else if (div_busy) begin
      if (dv_cnt == 1) begin
        div_busy <= 1'b0;
        div_q    <= dv_a / dv_b;
        div_r    <= dv_a % dv_b;
      end
      dv_cnt <= dv_cnt - 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = b;
    @(posedge clock); #1;
    op_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  logic [31:0] neg100, exp_lo, exp_hi;
  int          cnt, s;

  initial begin
    resetn = 1'b0; op_valid = 1'b1; op_code = OP_MFHI; op_a = '0; op_b = '0; flush = 1'b0;
    cycles(2);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    check_eq("rst_start", {31'd0, div_start}, 32'd0);
    check_eq("rst_div_a", div_a, 32'd0);
    check_eq("rst_div_b", div_b, 32'd0);
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_rd", rd_data, 32'd0);
    resetn = 1'b1; op_valid = 1'b0;
    cycles(1);

    issue(OP_MTHI, 32'h1234, 32'd0);
    op_valid = 1'b1; op_code = OP_MFHI; #1;
    check_eq("mfhi_bypass", rd_data, 32'h1234);
    check_eq("mfhi_stall", {31'd0, stall}, 32'd0);
    op_valid = 1'b0;
    issue(OP_MTLO, 32'h55AA, 32'd0);
    op_valid = 1'b1; op_code = OP_MFLO; #1;
    check_eq("mflo_mt", rd_data, 32'h55AA);
    op_valid = 1'b0;

    // DIVU 100/7 with an MFLO held behind it
    issue(OP_DIVU, 32'd100, 32'd7);
    check_eq("launch_div_a", div_a, 32'd100);
    check_eq("launch_div_b", div_b, 32'd7);
    check_eq("launch_start", {31'd0, div_start}, 32'd1);
    op_valid = 1'b1; op_code = OP_MFLO; #1;
    cnt = 0;
    while (stall && cnt < 100) begin
      if (cnt == 34) check_eq("lo_before_fix", lo, 32'h55AA);
      cnt++;
      @(posedge clock); #1;
    end
    check_eq("stall_cycles", cnt, 32'd35);
    check_eq("divu_rd_lo", rd_data, 32'd14);
    check_eq("divu_hi", hi, 32'd2);
    check_eq("divu_one_start", n_start, 32'd1);
    @(posedge clock); #1;
    op_valid = 1'b0;

    // DIV -100/7
    neg100 = 32'hFFFFFF9C;
`ifdef HILO_DIV_SIGNED_EN
    exp_lo = 32'hFFFFFFF2; exp_hi = 32'hFFFFFFFE;
`else
    exp_lo = neg100 / 32'd7; exp_hi = neg100 % 32'd7;
`endif
    issue(OP_DIV, neg100, 32'd7);
    cycles(35);
    check_eq("div_neg_lo", lo, exp_lo);
    check_eq("div_neg_hi", hi, exp_hi);

    // DIV most-negative by -1
`ifdef HILO_DIV_SIGNED_EN
    exp_lo = 32'h80000000; exp_hi = 32'h0;
`else
    exp_lo = 32'h0; exp_hi = 32'h80000000;
`endif
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    cycles(35);
    check_eq("div_min_lo", lo, exp_lo);
    check_eq("div_min_hi", hi, exp_hi);

    // divide by zero
    s = n_start;
    issue(OP_DIVU, 32'd5, 32'd0);
    check_eq("dz_hi", hi, 32'd5);
    check_eq("dz_lo", lo, 32'hFFFFFFFF);
    cycles(3);
    check_eq("dz_no_start", n_start, s);

    // flush at cycle 10, then an immediate DIVU 9/3
    issue(OP_DIVU, 32'd1000, 32'd10);
    cycles(10);
    flush = 1'b1; op_valid = 1'b1; op_code = OP_MFHI; #1;
    check_eq("flush_stall_before", {31'd0, stall}, 32'd1);
    @(posedge clock); #1;
    flush = 1'b0;
    check_eq("flush_idle", {31'd0, stall}, 32'd0);
    check_eq("flush_hi", rd_data, 32'd5);
    check_eq("flush_lo", lo, 32'hFFFFFFFF);
    op_valid = 1'b0;
    issue(OP_DIVU, 32'd9, 32'd3);
    cycles(35);
    check_eq("after_flush_lo", lo, 32'd3);
    check_eq("after_flush_hi", hi, 32'd0);

    // reset in the middle of WAIT
    issue(OP_DIVU, 32'd100, 32'd7);
    cycles(10);
    resetn = 1'b0; op_valid = 1'b1; op_code = OP_MFLO;
    @(posedge clock); #1;
    check_eq("mid_rst_hi", hi, 32'd0);
    check_eq("mid_rst_lo", lo, 32'd0);
    check_eq("mid_rst_start", {31'd0, div_start}, 32'd0);
    check_eq("mid_rst_div_a", div_a, 32'd0);
    check_eq("mid_rst_div_b", div_b, 32'd0);
    check_eq("mid_rst_stall", {31'd0, stall}, 32'd0);
    check_eq("mid_rst_rd", rd_data, 32'd0);
    resetn = 1'b1; op_valid = 1'b0;
    cycles(40);
    check_eq("no_late_hi", hi, 32'd0);
    check_eq("no_late_lo", lo, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
